// File: rtl/ex_mem_elastic_reg_if.sv
// Handshake and payload bundle between the execute stage, the EX/MEM elastic
// register and the memory stage. The slave view belongs to the register itself.
interface ex_mem_elastic_reg_if #(
    parameter int DATA_W = 64,
    parameter int LANES  = 3,
    parameter int CTRL_W = 6,
    parameter int META_W = 11,
    parameter int KCNT_W = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [CTRL_W-1:0]       in_ctrl;
    logic [META_W-1:0]       in_meta;
    logic [LANES*DATA_W-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [CTRL_W-1:0]       out_ctrl;
    logic [META_W-1:0]       out_meta;
    logic [LANES*DATA_W-1:0] out_data;
    logic [1:0]              occupancy;
    logic [KCNT_W-1:0]       kill_cnt;

    modport slave (
        input  in_valid, in_ctrl, in_meta, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_meta, out_data, occupancy, kill_cnt
    );

    modport master (
        output in_valid, in_ctrl, in_meta, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_meta, out_data, occupancy, kill_cnt
    );
endinterface

// File: rtl/ex_mem_elastic_reg.sv
// EX/MEM pipeline register with valid/ready handshake, two-entry skid storage,
// flush with a saturating kill counter, and control bits zeroed on bubbles.
module ex_mem_elastic_reg #(
    parameter int DATA_W = 64,
    parameter int LANES  = 3,
    parameter int CTRL_W = 6,
    parameter int META_W = 11,
    parameter int KCNT_W = 8
) (
    input logic                  clk,
    input logic                  reset,
    input logic                  flush,
    ex_mem_elastic_reg_if.slave  bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [CTRL_W-1:0]       ctrl;
        logic [META_W-1:0]       meta;
        logic [LANES*DATA_W-1:0] data;
    } entry_t;

    localparam logic [KCNT_W+1:0] KILL_MAX_WIDE = {2'b00, {KCNT_W{1'b1}}};

    state_t            state_q, state_d;
    entry_t            main_q, main_d;
    entry_t            skid_q, skid_d;
    entry_t            in_entry;
    logic [KCNT_W-1:0] kill_q, kill_d;
    logic [KCNT_W+1:0] kill_sum;
    logic              in_ready;
    logic              out_valid;
    logic              acc;
    logic              pop;

    assign in_entry  = {bus.in_ctrl, bus.in_meta, bus.in_data};

    // Readiness depends on registered state only, so out_ready never reaches in_ready.
    assign in_ready  = (state_q != FULL) && !reset;
    assign out_valid = (state_q != EMPTY);
    assign acc       = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_ctrl  = out_valid ? main_q.ctrl : '0;
    assign bus.out_meta  = main_q.meta;
    assign bus.out_data  = main_q.data;
    assign bus.occupancy = state_q;
    assign bus.kill_cnt  = kill_q;

    // Everything held (including an entry popped or accepted this cycle) is counted as killed.
    assign kill_sum = {2'b00, kill_q}
                    + {{KCNT_W{1'b0}}, state_q}
                    + {{(KCNT_W+1){1'b0}}, acc};

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        kill_d  = kill_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
            kill_d  = (kill_sum > KILL_MAX_WIDE) ? {KCNT_W{1'b1}} : kill_sum[KCNT_W-1:0];
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        main_d  = in_entry;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (acc && pop) begin
                        main_d = in_entry;
                    end else if (acc) begin
                        skid_d  = in_entry;
                        state_d = FULL;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            kill_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            kill_q  <= kill_d;
        end
    end
endmodule

// File: tb/tb_ex_mem_elastic_reg.sv
// Self-checking bench for ex_mem_elastic_reg: scoreboard on the handshake plus
// a vector table for per-cycle occupancy, readiness, kill count and head lane.
module tb_ex_mem_elastic_reg;
    localparam int KW = 2;

    typedef struct packed {
        logic [5:0]   ctrl;
        logic [10:0]  meta;
        logic [191:0] data;
    } ent_t;

    typedef struct {
        bit         rst;
        bit         fl;
        bit         iv;
        bit         ordy;
        logic [7:0] lane;
        logic [1:0] occ;
        bit         ir;
        logic [1:0] kill;
        logic [7:0] exp_lane;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_cycle  = 0;
    ent_t sb[$];
    vec_t vecs[$];

    ex_mem_elastic_reg_if #(.KCNT_W(KW)) bus ();

    ex_mem_elastic_reg #(.KCNT_W(KW)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic ent_t mk(input logic [7:0] v);
        ent_t e;
        e.ctrl = {v[1:0], 4'b1001};
        e.meta = {3'b101, v};
        e.data = {64'hC3C3_0000_0000_0000 | {56'h0, v}, ~{56'h0, v}, {56'h0, v}};
        return e;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input bit rst, input bit fl, input bit iv, input bit ordy, input ent_t e);
        bit acc;
        bit pop;
        reset         = rst;
        flush         = fl;
        bus.in_valid  = iv;
        bus.in_ctrl   = e.ctrl;
        bus.in_meta   = e.meta;
        bus.in_data   = e.data;
        bus.out_ready = ordy;
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        pop = bus.out_valid && bus.out_ready;
        if (pop && !rst) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_empty: got pop with empty scoreboard, required no pop");
            end else begin
                chk("pop_entry", 256'({bus.out_ctrl, bus.out_meta, bus.out_data}), 256'(sb[0]));
            end
        end
        if (rst || fl) begin
            sb.delete();
        end else begin
            if (pop && sb.size() != 0) void'(sb.pop_front());
            if (acc) sb.push_back(e);
        end
        @(posedge clk);
        #1;
        n_cycle++;
        $display("cycle %0d: rst=%0b flush=%0b acc=%0b pop=%0b occ=%0d kill=%0d lane0=%0h",
                 n_cycle, rst, fl, acc, pop, bus.occupancy, bus.kill_cnt, bus.out_data[63:0]);
        chk("occ_model", 256'(bus.occupancy), 256'(sb.size()));
        if (!bus.out_valid) chk("bubble_ctrl", 256'(bus.out_ctrl), 256'(0));
    endtask

    function automatic void add(input bit rst, input bit fl, input bit iv, input bit ordy,
                                input logic [7:0] lane, input logic [1:0] occ, input bit ir,
                                input logic [1:0] kill, input logic [7:0] exp_lane);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.ordy = ordy; v.lane = lane;
        v.occ = occ; v.ir = ir; v.kill = kill; v.exp_lane = exp_lane;
        vecs.push_back(v);
    endfunction

    initial begin
        ent_t e;
        reset         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_ctrl   = '0;
        bus.in_meta   = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset for two cycles, then a single entry and the bubble after it.
        step(1, 0, 0, 0, '0);
        step(1, 0, 0, 0, '0);
        chk("rst_occ", 256'(bus.occupancy), 256'(0));
        chk("rst_out_valid", 256'(bus.out_valid), 256'(0));
        chk("rst_in_ready", 256'(bus.in_ready), 256'(0));
        chk("rst_kill", 256'(bus.kill_cnt), 256'(0));
        chk("rst_out_data", 256'(bus.out_data), 256'(0));
        chk("rst_out_meta", 256'(bus.out_meta), 256'(0));
        e      = '0;
        e.ctrl = 6'b000011;
        e.meta = 11'h055;
        e.data = 192'h10;
        step(0, 0, 1, 1, e);
        chk("single_out_valid", 256'(bus.out_valid), 256'(1));
        chk("single_out_ctrl", 256'(bus.out_ctrl), 256'(3));
        chk("single_out_meta", 256'(bus.out_meta), 256'(11'h055));
        chk("single_lane0", 256'(bus.out_data[63:0]), 256'(64'h10));
        chk("single_occ", 256'(bus.occupancy), 256'(1));
        step(0, 0, 0, 1, '0);
        chk("bubble_out_valid", 256'(bus.out_valid), 256'(0));
        chk("bubble_out_ctrl", 256'(bus.out_ctrl), 256'(0));
        chk("bubble_lane0", 256'(bus.out_data[63:0]), 256'(64'h10));

        //   rst fl iv or lane   occ ir kill exp_lane
        // Backpressure fill and drain.
        add(0, 0, 1, 0, 8'h01, 1, 1, 0, 8'h01);
        add(0, 0, 1, 0, 8'h02, 2, 0, 0, 8'h01);
        add(0, 0, 1, 0, 8'h03, 2, 0, 0, 8'h01);
        add(0, 0, 1, 1, 8'h03, 1, 1, 0, 8'h02);
        add(0, 0, 1, 1, 8'h03, 1, 1, 0, 8'h03);
        add(0, 0, 0, 1, 8'h00, 0, 1, 0, 8'h03);
        // Streaming at one entry per cycle.
        for (int i = 0; i < 8; i++) add(0, 0, 1, 1, 8'(i), 1, 1, 0, 8'(i));
        add(0, 0, 0, 1, 8'h00, 0, 1, 0, 8'h07);
        // Flush in ONE with an accepted input: both entries counted, input dropped.
        add(0, 0, 1, 0, 8'h50, 1, 1, 0, 8'h50);
        add(0, 1, 1, 0, 8'h51, 0, 1, 2, 8'h00);
        add(0, 0, 0, 0, 8'h00, 0, 1, 2, 8'h00);
        // Flush in FULL with a blocked push; kill counter saturates at 3.
        add(0, 0, 1, 0, 8'h40, 1, 1, 2, 8'h40);
        add(0, 0, 1, 0, 8'h41, 2, 0, 2, 8'h40);
        add(0, 1, 1, 0, 8'h42, 0, 1, 3, 8'h00);
        // Flush with a simultaneous pop and accept; counter stays saturated.
        add(0, 0, 1, 1, 8'h60, 1, 1, 3, 8'h60);
        add(0, 1, 1, 1, 8'h61, 0, 1, 3, 8'h00);

        foreach (vecs[k]) begin
            step(vecs[k].rst, vecs[k].fl, vecs[k].iv, vecs[k].ordy, mk(vecs[k].lane));
            chk("vec_occ", 256'(bus.occupancy), 256'(vecs[k].occ));
            chk("vec_in_ready", 256'(bus.in_ready), 256'(vecs[k].ir));
            chk("vec_kill", 256'(bus.kill_cnt), 256'(vecs[k].kill));
            chk("vec_out_valid", 256'(bus.out_valid), 256'(vecs[k].occ != 0));
            chk("vec_lane0", 256'(bus.out_data[63:0]), 256'({56'h0, vecs[k].exp_lane}));
        end

        // Reset asserted while FULL discards everything without counting it.
        step(0, 0, 1, 0, mk(8'h70));
        step(0, 0, 1, 0, mk(8'h71));
        chk("pre_reset_occ", 256'(bus.occupancy), 256'(2));
        step(1, 0, 1, 1, mk(8'h72));
        chk("midrst_occ", 256'(bus.occupancy), 256'(0));
        chk("midrst_out_valid", 256'(bus.out_valid), 256'(0));
        chk("midrst_out_ctrl", 256'(bus.out_ctrl), 256'(0));
        chk("midrst_out_meta", 256'(bus.out_meta), 256'(0));
        chk("midrst_out_data", 256'(bus.out_data), 256'(0));
        chk("midrst_kill", 256'(bus.kill_cnt), 256'(0));
        chk("midrst_in_ready", 256'(bus.in_ready), 256'(0));
        step(0, 0, 0, 0, '0);
        chk("post_rst_in_ready", 256'(bus.in_ready), 256'(1));
        chk("post_rst_occ", 256'(bus.occupancy), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
